// File: rtl/defines.sv
// Shared widths, funct3 encodings and the MEM-stage access state type.
package defines;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: byte enables, store-data replication, load extraction
// and extension, and misalignment / illegal-size detection.
module lsu_align
    import defines::*;
(
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    input  logic [DATA_WIDTH-1:0] rdata_in,
    output logic [BE_WIDTH-1:0]   be,
    output logic [DATA_WIDTH-1:0] wdata_out,
    output logic [DATA_WIDTH-1:0] rdata_out,
    output logic                  misalign
);

    logic [DATA_WIDTH-1:0] shifted;

    // Size decode: lanes, replication and sign/zero extension per funct3
    always_comb begin
        be        = '0;
        wdata_out = '0;
        rdata_out = '0;
        misalign  = 1'b0;
        shifted   = rdata_in >> {addr_lo, 3'b000};
        case (funct3)
            F3_B, F3_BU: begin
                be        = BE_WIDTH'(4'b0001 << addr_lo);
                wdata_out = {BE_WIDTH{wdata_in[7:0]}};
                rdata_out = (funct3 == F3_B)
                          ? {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]}
                          : {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                misalign  = addr_lo[0];
                be        = BE_WIDTH'(4'b0011 << addr_lo);
                wdata_out = {(DATA_WIDTH/16){wdata_in[15:0]}};
                rdata_out = (funct3 == F3_H)
                          ? {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]}
                          : {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            end
            F3_W: begin
                misalign  = (addr_lo != 2'b00);
                be        = '1;
                wdata_out = wdata_in;
                rdata_out = rdata_in;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: one bus transaction per access, stalling the
// pipeline from issue until the DONE cycle.
module mem_access
    import defines::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_MEM,
    input  logic                  MemRead_MEM,
    input  logic                  MemWrite_MEM,
    input  logic [2:0]            funct3_MEM,
    input  logic [DATA_WIDTH-1:0] alu_result_MEM,
    input  logic [DATA_WIDTH-1:0] rs2_data_MEM,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [BE_WIDTH-1:0]   dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic [DATA_WIDTH-1:0] rd_data_MEM,
    output logic                  mem_stall,
    output logic                  misalign_MEM
);

    mem_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [2:0]            f3_q, f3_d;
    logic                  we_q, we_d;

    logic                  access_c;
    logic [2:0]            sel_f3;
    logic [1:0]            sel_addr_lo;
    logic [BE_WIDTH-1:0]   lsu_be;
    logic [DATA_WIDTH-1:0] lsu_wdata;
    logic [DATA_WIDTH-1:0] lsu_rdata;
    logic                  lsu_misalign;

    assign access_c = valid_MEM & (MemRead_MEM | MemWrite_MEM);

    // In IDLE the aligner judges the incoming access; afterwards the held one
    assign sel_f3      = (state_q == IDLE) ? funct3_MEM : f3_q;
    assign sel_addr_lo = (state_q == IDLE) ? alu_result_MEM[1:0] : addr_q[1:0];

    lsu_align u_lsu_align (
        .funct3    (sel_f3),
        .addr_lo   (sel_addr_lo),
        .wdata_in  (wdata_q),
        .rdata_in  (rdata_q),
        .be        (lsu_be),
        .wdata_out (lsu_wdata),
        .rdata_out (lsu_rdata),
        .misalign  (lsu_misalign)
    );

    // Next-state and request capture; both-high read/write resolves to store
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        f3_d    = f3_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (access_c && !lsu_misalign) begin
                    state_d = REQ;
                    addr_d  = alu_result_MEM;
                    wdata_d = rs2_data_MEM;
                    f3_d    = funct3_MEM;
                    we_d    = MemWrite_MEM;
                end
            end
            REQ: begin
                if (dmem_req_ready) begin
                    state_d = we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dmem_rsp_valid) begin
                    rdata_d = dmem_rdata;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus, stall and load-result outputs decoded from the current state
    always_comb begin
        dmem_req_valid = (state_q == REQ);
        dmem_we        = 1'b0;
        dmem_addr      = '0;
        dmem_be        = '0;
        dmem_wdata     = '0;
        mem_stall      = 1'b0;
        misalign_MEM   = 1'b0;
        rd_data_MEM    = '0;
        case (state_q)
            IDLE: begin
                misalign_MEM = access_c & lsu_misalign;
                mem_stall    = access_c & ~lsu_misalign;
            end
            REQ: begin
                dmem_we    = we_q;
                dmem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
                dmem_be    = lsu_be;
                dmem_wdata = lsu_wdata;
                mem_stall  = 1'b1;
            end
            WAIT:    mem_stall   = 1'b1;
            DONE:    rd_data_MEM = lsu_rdata;
            default: ;
        endcase
    end

    // State and held-request registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: inputs change 1 time unit after the rising
// edge, outputs are sampled 1 time unit later.
module tb_mem_access;
    import defines::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  valid_MEM, MemRead_MEM, MemWrite_MEM;
    logic [2:0]            funct3_MEM;
    logic [DATA_WIDTH-1:0] alu_result_MEM, rs2_data_MEM;
    logic                  dmem_req_valid, dmem_req_ready, dmem_we;
    logic [DATA_WIDTH-1:0] dmem_addr, dmem_wdata, dmem_rdata, rd_data_MEM;
    logic [BE_WIDTH-1:0]   dmem_be;
    logic                  dmem_rsp_valid, mem_stall, misalign_MEM;

    int checks = 0;
    int errors = 0;

    mem_access dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_MEM      (valid_MEM),
        .MemRead_MEM    (MemRead_MEM),
        .MemWrite_MEM   (MemWrite_MEM),
        .funct3_MEM     (funct3_MEM),
        .alu_result_MEM (alu_result_MEM),
        .rs2_data_MEM   (rs2_data_MEM),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .rd_data_MEM    (rd_data_MEM),
        .mem_stall      (mem_stall),
        .misalign_MEM   (misalign_MEM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_acc(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        valid_MEM      = 1'b1;
        MemRead_MEM    = rd;
        MemWrite_MEM   = wr;
        funct3_MEM     = f3;
        alu_result_MEM = addr;
        rs2_data_MEM   = wd;
    endtask

    task automatic clr_acc();
        valid_MEM    = 1'b0;
        MemRead_MEM  = 1'b0;
        MemWrite_MEM = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int stall_cnt, req_seen, wait_seen, hs, done;

        rst_n = 1'b0;
        clr_acc();
        funct3_MEM = 3'b000; alu_result_MEM = '0; rs2_data_MEM = '0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
        cyc(); cyc();
        #1;
        chk("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        chk("rst_stall",     32'(mem_stall),      32'd0);
        chk("rst_rd_data",   rd_data_MEM,         32'd0);
        chk("rst_bus_addr",  dmem_addr,           32'd0);

        // SB 0x103, immediate ready
        cyc(); rst_n = 1'b1;
        cyc();
        dmem_req_ready = 1'b1;
        set_acc(1'b0, 1'b1, F3_B, 32'h103, 32'hAB); #1;
        chk("sb_idle_stall", 32'(mem_stall),      32'd1);
        chk("sb_idle_noreq", 32'(dmem_req_valid), 32'd0);
        cyc();
        chk("sb_req_valid",  32'(dmem_req_valid), 32'd1);
        chk("sb_we",         32'(dmem_we),        32'd1);
        chk("sb_addr",       dmem_addr,           32'h100);
        chk("sb_be",         32'(dmem_be),        32'b1000);
        chk("sb_wdata",      dmem_wdata,          32'hABABABAB);
        chk("sb_req_stall",  32'(mem_stall),      32'd1);
        cyc();
        chk("sb_done_stall", 32'(mem_stall),      32'd0);
        chk("sb_done_noreq", 32'(dmem_req_valid), 32'd0);
        cyc(); clr_acc(); #1;
        chk("idle_stall",    32'(mem_stall),      32'd0);

        // LB then LBU at 0x102 returning 0x0080_0000
        for (int k = 0; k < 2; k++) begin
            cyc();
            set_acc(1'b1, 1'b0, (k == 0) ? F3_B : F3_BU, 32'h102, 32'h0); #1;
            cyc();
            chk("lb_req_we",   32'(dmem_we),  32'd0);
            chk("lb_req_be",   32'(dmem_be),  32'b0100);
            cyc();
            dmem_rsp_valid = 1'b1; dmem_rdata = 32'h0080_0000; #1;
            chk("lb_wait_stall", 32'(mem_stall), 32'd1);
            chk("lb_wait_rd0",   rd_data_MEM,    32'd0);
            cyc();
            dmem_rsp_valid = 1'b0; #1;
            chk((k == 0) ? "lb_result" : "lbu_result", rd_data_MEM,
                (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
            cyc(); clr_acc(); #1;
            chk("ld_after_rd0", rd_data_MEM, 32'd0);
        end

        // LW 0x200: ready on third request cycle, response on third wait cycle
        cyc();
        dmem_req_ready = 1'b0;
        set_acc(1'b1, 1'b0, F3_W, 32'h200, 32'h0);
        stall_cnt = 0; req_seen = 0; wait_seen = 0; hs = 0; done = 0;
        for (int i = 0; i < 30 && done == 0; i++) begin
            #1;
            if (mem_stall) stall_cnt++;
            if (dmem_req_valid) begin
                req_seen++;
                chk("lw_hold_addr", dmem_addr,          32'h200);
                chk("lw_hold_be",   32'(dmem_be),       32'hF);
                chk("lw_hold_we",   32'(dmem_we),       32'd0);
                dmem_req_ready = (req_seen == 3);
                if (req_seen == 3) hs++;
            end else begin
                dmem_req_ready = 1'b0;
                if (mem_stall && hs == 1) begin
                    wait_seen++;
                    dmem_rsp_valid = (wait_seen == 3);
                    dmem_rdata     = 32'h12345678;
                end
            end
            if (!mem_stall && hs == 1) begin
                done = 1;
                dmem_rsp_valid = 1'b0;
                chk("lw_result", rd_data_MEM, 32'h12345678);
            end
            if (done == 0) begin
                @(posedge clk);
                #0;
            end
        end
        chk("lw_done_reached", 32'(done),      32'd1);
        chk("lw_stall_cycles", 32'(stall_cnt), 32'd7);
        chk("lw_handshakes",   32'(hs),        32'd1);
        cyc(); clr_acc(); dmem_req_ready = 1'b1; #1;
        chk("lw_no_reissue", 32'(dmem_req_valid), 32'd0);

        // LH 0x101 misaligned, then illegal funct3 011
        cyc();
        set_acc(1'b1, 1'b0, F3_H, 32'h101, 32'h0); #1;
        chk("lh_mis_flag",  32'(misalign_MEM),   32'd1);
        chk("lh_mis_stall", 32'(mem_stall),      32'd0);
        cyc();
        chk("lh_mis_noreq", 32'(dmem_req_valid), 32'd0);
        funct3_MEM = 3'b011; alu_result_MEM = 32'h100; #1;
        chk("f3_011_mis",   32'(misalign_MEM),   32'd1);
        cyc(); clr_acc(); #1;
        chk("mis_noreq2",   32'(dmem_req_valid), 32'd0);
        chk("mis_flag_clr", 32'(misalign_MEM),   32'd0);

        // SH 0x102 data 0xBEEF
        cyc();
        set_acc(1'b0, 1'b1, F3_H, 32'h102, 32'h0000BEEF);
        cyc();
        chk("sh_be",    32'(dmem_be), 32'b1100);
        chk("sh_wdata", dmem_wdata,   32'hBEEFBEEF);
        cyc(); cyc(); clr_acc();

        // Reset in WAIT, then a late response
        cyc();
        set_acc(1'b1, 1'b0, F3_W, 32'h300, 32'h0);
        cyc(); cyc();
        chk("rst_in_wait_stall", 32'(mem_stall), 32'd1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; clr_acc();
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'hDEADBEEF; #1;
        chk("rstw_stall", 32'(mem_stall), 32'd0);
        chk("rstw_rd",    rd_data_MEM,    32'd0);
        cyc();
        dmem_rsp_valid = 1'b0; #1;
        chk("rstw_no_done", rd_data_MEM,         32'd0);
        chk("rstw_noreq",   32'(dmem_req_valid), 32'd0);

        // Back-to-back SW 0x400 then LW 0x404
        cyc();
        set_acc(1'b0, 1'b1, F3_W, 32'h400, 32'h11223344);
        cyc();
        chk("sw_req",   32'(dmem_req_valid), 32'd1);
        chk("sw_we",    32'(dmem_we),        32'd1);
        chk("sw_wdata", dmem_wdata,          32'h11223344);
        chk("sw_be",    32'(dmem_be),        32'hF);
        cyc();
        chk("sw_done_stall", 32'(mem_stall), 32'd0);
        cyc();
        set_acc(1'b1, 1'b0, F3_W, 32'h404, 32'h0); #1;
        chk("b2b_idle_noreq", 32'(dmem_req_valid), 32'd0);
        chk("b2b_idle_stall", 32'(mem_stall),      32'd1);
        cyc();
        chk("lw2_req",  32'(dmem_req_valid), 32'd1);
        chk("lw2_we",   32'(dmem_we),        32'd0);
        chk("lw2_addr", dmem_addr,           32'h404);
        cyc();
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'hCAFEF00D;
        cyc();
        dmem_rsp_valid = 1'b0; #1;
        chk("lw2_result", rd_data_MEM, 32'hCAFEF00D);
        cyc(); clr_acc(); #1;
        chk("end_idle", 32'(mem_stall), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset; synchronous, active-low.
REQ-003 valid_MEM  input  1  instruction present in the MEM stage.
REQ-004 MemRead_MEM / MemWrite_MEM  input  1 each  load / store request; both high is illegal and treated as store.
REQ-005 funct3_MEM  input  3  access size/sign: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
REQ-006 alu_result_MEM  input  DATA_WIDTH  effective byte address.
REQ-007 rs2_data_MEM  input  DATA_WIDTH  store data, right-justified.
REQ-008 dmem_req_valid  output  1  bus request valid.
REQ-009 dmem_req_ready  input  1  bus accepts request.
REQ-010 dmem_we  output  1  1 = write.
REQ-011 dmem_addr  output  DATA_WIDTH  word-aligned address; addr[1:0] = 00.
REQ-012 dmem_be  output  4  byte enables.
REQ-013 dmem_wdata  output  DATA_WIDTH  lane-replicated store data.
REQ-014 dmem_rsp_valid  input  1  read data valid.
REQ-015 dmem_rdata  input  DATA_WIDTH  read word.
REQ-016 rd_data_MEM  output  DATA_WIDTH  aligned and extended load result for MEM/WB.
REQ-017 mem_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM; bubbles MEM/WB.
REQ-018 misalign_MEM  output  1  misaligned address or illegal funct3 on the current access.

Function
REQ-019 States: IDLE, REQ, WAIT, DONE (mem_state_e).
REQ-020 Access = valid_MEM & (MemRead_MEM | MemWrite_MEM).
REQ-021 Misaligned = halfword with addr[0]=1, word with addr[1:0]≠00, or funct3 ∈ {011, 110, 111}.
REQ-022 Misaligned access: misalign_MEM=1 combinationally, no bus request, mem_stall=0, state stays IDLE.
REQ-023 IDLE: an aligned access drives mem_stall=1 combinationally and moves to REQ next cycle.
REQ-024 REQ: dmem_req_valid=1, mem_stall=1; address, we, be and wdata are held stable until dmem_req_ready.
REQ-025 REQ handshake, store: next state DONE.
REQ-026 REQ handshake, load: next state WAIT.
REQ-027 WAIT: mem_stall=1; on dmem_rsp_valid, dmem_rdata is captured into a register and the next state is DONE.
REQ-028 DONE: mem_stall=0 for exactly one cycle; rd_data_MEM valid for loads; next state IDLE unconditionally, and the held access is not reissued.
REQ-029 Minimum latency, zero-wait bus: store 3 cycles, load 4 cycles (IDLE→REQ→WAIT→DONE).
REQ-030 A response arriving in the handshake cycle is not legal; the bus responds no earlier than the cycle after the handshake.
REQ-031 Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-032 Store data: byte replicated to all four lanes; half replicated to both halves; word passed through.
REQ-033 Load: select byte/half by addr[1:0]; sign-extend LB/LH; zero-extend LBU/LHU; LW passes through.
REQ-034 rd_data_MEM is the extracted captured word in DONE and 0 in all other states.
REQ-035 dmem_rsp_valid outside WAIT is ignored.
REQ-036 valid_MEM=0, or no access: all bus outputs 0, mem_stall=0.

Reset
REQ-037 Reset values: state IDLE, captured data 0, dmem_req_valid 0, mem_stall 0, rd_data_MEM 0.
REQ-038 Reset in REQ or WAIT abandons the transaction; a late response after reset is ignored under REQ-035.

Structure
REQ-039 mem_state_e and the funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU live in package defines; DATA_WIDTH comes from defines.
REQ-040 Combinational sub-module lsu_align: inputs funct3 and addr[1:0] plus wdata/rdata; outputs be, wdata, extended rdata and misalign.

Verification
REQ-041 SB, addr 0x103, rs2 0xAB, ready immediate → be 1000, wdata 0xABABABAB, addr 0x100, mem_stall high 2 cycles.
REQ-042 LB, addr 0x102, rdata 0x0080_0000 → rd_data_MEM 0xFFFFFF80; same access as LBU → 0x00000080.
REQ-043 LW, ready delayed 3 cycles, rsp delayed 2 cycles → req fields stable throughout, total stall 7 cycles, single request issued.
REQ-044 LH at addr 0x101 → misalign_MEM=1, dmem_req_valid never asserted, mem_stall=0.
REQ-045 rst_n low during WAIT, then rsp_valid=1 → state IDLE, rd_data_MEM=0, no DONE cycle.
REQ-046 Back-to-back SW then LW → two distinct handshakes, DONE of the store precedes REQ of the load by one IDLE cycle.
